inst_encoder: RTL and testbench

- Inverse of the immediate generator: packs decoded fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) into a 32-bit RV32I instruction word.
- Range-checks the immediate, then writes the word into instruction memory at an auto-incrementing address.
- Used by the test/boot loader path to build program images in IMEM.
- Bit placement is exactly the one the decode side un-packs, so encode→decode round-trips.

---
 rtl/inst_pkg.sv | 30 +++
 rtl/inst_encoder_imm_pack.sv | 62 ++++++
 rtl/inst_encoder.sv | 135 +++++++++++++
 tb/tb_inst_encoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared RV32I encoding constants and FSM state type for the instruction encoder.
package inst_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // True when value[31:lsb] are all copies of one bit, i.e. value fits a signed field ending at lsb
  function automatic logic upper_uniform(input logic [31:0] value, input logic [4:0] lsb);
    logic [31:0] shifted;
    shifted = $signed(value) >>> lsb;
    return (shifted == 32'h0000_0000) || (shifted == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational packer: places decoded fields and the immediate into an RV32I word
// and flags immediates that do not fit the selected format.
module imm_pack
  import inst_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  // Format selection by opcode; shift-immediates reuse funct7 and a 5-bit shamt
  always_comb begin
    word      = 32'h0000_0000;
    range_err = 1'b0;
    case (opcode)
      OP_R: begin
        word      = {funct7, rs2_addr, rs1_addr, funct3, rd_addr, opcode};
        range_err = 1'b0;
      end
      OP_IMM: begin
        if ((funct3 == F3_SLLI) || (funct3 == F3_SRXI)) begin
          word      = {funct7, imm[4:0], rs1_addr, funct3, rd_addr, opcode};
          range_err = (imm[31:5] != 27'd0);
        end else begin
          word      = {imm[11:0], rs1_addr, funct3, rd_addr, opcode};
          range_err = !upper_uniform(imm, 5'd11);
        end
      end
      OP_LOAD, OP_JALR: begin
        word      = {imm[11:0], rs1_addr, funct3, rd_addr, opcode};
        range_err = !upper_uniform(imm, 5'd11);
      end
      OP_STORE: begin
        word      = {imm[11:5], rs2_addr, rs1_addr, funct3, imm[4:0], opcode};
        range_err = !upper_uniform(imm, 5'd11);
      end
      OP_BRANCH: begin
        word      = {imm[12], imm[10:5], rs2_addr, rs1_addr, funct3, imm[4:1], imm[11], opcode};
        range_err = imm[0] | !upper_uniform(imm, 5'd12);
      end
      OP_LUI, OP_AUIPC: begin
        word      = {imm[31:12], rd_addr, opcode};
        range_err = (imm[11:0] != 12'd0);
      end
      OP_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd_addr, opcode};
        range_err = imm[0] | !upper_uniform(imm, 5'd20);
      end
      default: begin
        word      = {25'd0, opcode};
        range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts a decoded field bundle, packs and range-checks it,
// then writes the word to IMEM at an auto-incrementing byte address.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd_addr,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [7:0]        err_cnt
);

  state_e            state_r;
  logic              in_ready_r;
  logic              mem_we_r;
  logic [31:0]       mem_wdata_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              err_r;
  logic [7:0]        err_cnt_r;

  logic [6:0]  opcode_r;
  logic [4:0]  rd_r;
  logic [4:0]  rs1_r;
  logic [4:0]  rs2_r;
  logic [2:0]  funct3_r;
  logic [6:0]  funct7_r;
  logic [31:0] imm_r;

  logic [31:0] word_s;
  logic        range_err_s;

  imm_pack u_imm_pack (
    .opcode    (opcode_r),
    .rd_addr   (rd_r),
    .rs1_addr  (rs1_r),
    .rs2_addr  (rs2_r),
    .funct3    (funct3_r),
    .funct7    (funct7_r),
    .imm       (imm_r),
    .word      (word_s),
    .range_err (range_err_s)
  );

  // Control FSM: capture in IDLE, encode/check in ENC, hold the write until IMEM accepts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 32'h0000_0000;
      ptr_r       <= RESET_ADDR;
      err_r       <= 1'b0;
      err_cnt_r   <= 8'd0;
      opcode_r    <= 7'd0;
      rd_r        <= 5'd0;
      rs1_r       <= 5'd0;
      rs2_r       <= 5'd0;
      funct3_r    <= 3'd0;
      funct7_r    <= 7'd0;
      imm_r       <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A same-cycle base_load retargets the bundle being accepted
          if (base_load) begin
            ptr_r <= base_addr;
          end
          if (in_valid) begin
            opcode_r   <= opcode;
            rd_r       <= rd_addr;
            rs1_r      <= rs1_addr;
            rs2_r      <= rs2_addr;
            funct3_r   <= funct3;
            funct7_r   <= funct7;
            imm_r      <= imm;
            in_ready_r <= 1'b0;
            state_r    <= ST_ENC;
          end
        end
        ST_ENC: begin
          mem_wdata_r <= word_s;
          if (range_err_s) begin
            err_r <= 1'b1;
            if (err_cnt_r != 8'hFF) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            mem_we_r <= 1'b1;
            state_r  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            mem_we_r   <= 1'b0;
            ptr_r      <= ptr_r + ADDR_W'(3'd4);
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          mem_we_r   <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = ptr_r;
  assign mem_wdata = mem_wdata_r;
  assign err       = err_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed cases plus randomized bundles
// checked against an arithmetic reference encoder.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic        base_load = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(32), .RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .funct3(funct3), .funct7(funct7), .imm(imm), .base_load(base_load),
    .base_addr(base_addr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .err(err), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_ptr = 32'd0;
  bit          m_err = 1'b0;
  int          m_err_cnt = 0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoder: field placement from the RV32I format tables, range via signed bounds
  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] iv, output logic [31:0] w, output bit bad);
    longint s;
    logic [31:0] opf, rdf, f3f, rs1f, rs2f, f7f;
    s    = longint'($signed(iv));
    opf  = {25'd0, op};
    rdf  = 32'(rd) << 7;
    f3f  = 32'(f3) << 12;
    rs1f = 32'(rs1) << 15;
    rs2f = 32'(rs2) << 20;
    f7f  = 32'(f7) << 25;
    bad  = 1'b0;
    w    = opf;
    if (op == 7'h33) begin
      w = opf | rdf | f3f | rs1f | rs2f | f7f;
    end else if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      w = opf | rdf | f3f | rs1f | ((iv % 32'd32) << 20) | f7f;
      bad = (iv > 32'd31);
    end else if (op == 7'h03 || op == 7'h13 || op == 7'h67) begin
      w = opf | rdf | f3f | rs1f | ((iv & 32'h0000_0FFF) << 20);
      bad = (s < -2048) || (s > 2047);
    end else if (op == 7'h23) begin
      w = opf | (fld(iv, 4, 0) << 7) | f3f | rs1f | rs2f | (fld(iv, 11, 5) << 25);
      bad = (s < -2048) || (s > 2047);
    end else if (op == 7'h63) begin
      w = opf | (fld(iv, 11, 11) << 7) | (fld(iv, 4, 1) << 8) | f3f | rs1f | rs2f
            | (fld(iv, 10, 5) << 25) | (fld(iv, 12, 12) << 31);
      bad = (s < -4096) || (s > 4095) || (iv % 32'd2 != 32'd0);
    end else if (op == 7'h37 || op == 7'h17) begin
      w = opf | rdf | (iv & 32'hFFFF_F000);
      bad = (iv % 32'd4096 != 32'd0);
    end else if (op == 7'h6F) begin
      w = opf | rdf | (fld(iv, 19, 12) << 12) | (fld(iv, 11, 11) << 20)
            | (fld(iv, 10, 1) << 21) | (fld(iv, 20, 20) << 31);
      bad = (s < -1048576) || (s > 1048575) || (iv % 32'd2 != 32'd0);
    end else begin
      bad = 1'b1;
    end
  endfunction

  function automatic logic [31:0] dec_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] dec_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  // Monitor: every accepted IMEM write is matched against the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", mem_addr, mon_e.addr);
        check("wr_data", mem_wdata, mon_e.word);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (in_ready !== 1'b1 && t < 300) begin
      if (rand_rdy) mem_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: in_ready %b, expected 1", in_ready);
    end
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] iv, input bit do_base, input logic [31:0] base,
                      input bit expect_write);
    logic [31:0] w;
    bit bad;
    wait_idle();
    opcode = op; rd_addr = rd; rs1_addr = rs1; rs2_addr = rs2;
    funct3 = f3; funct7 = f7; imm = iv;
    base_load = do_base; base_addr = base; in_valid = 1'b1;
    ref_encode(op, rd, rs1, rs2, f3, f7, iv, w, bad);
    if (do_base) m_ptr = base;
    if (bad) begin
      m_err = 1'b1;
      if (m_err_cnt < 255) m_err_cnt++;
    end else begin
      if (expect_write) sb_q.push_back({m_ptr, w});
      m_ptr = m_ptr + 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    base_load = 1'b0;
  endtask

  task automatic wait_we(output logic [31:0] w);
    int t = 0;
    while (mem_we !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL we_timeout: mem_we %b, expected 1", mem_we);
    end
    w = mem_wdata;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'(m_err_cnt));
    check({tag, "_ptr"}, mem_addr, m_ptr);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ptr = 32'd0; m_err = 1'b0; m_err_cnt = 0;
    sb_q.delete();
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    logic [6:0] ops[10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,-1: write appears on cycle 2 after acceptance
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1);
    check("addi_enc_no_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check("addi_we_cycle2", {31'd0, mem_we}, 32'd1);
    check("addi_addr", mem_addr, 32'd0);
    check("addi_wdata", mem_wdata, 32'hFFF0_0093);
    wait_idle();
    check("addi_ptr", mem_addr, 32'h4);

    // sw / beq / jal / lui from a clean pointer, with imm round-trip through decode
    do_reset();
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'd0, 1'b1);
    wait_we(w);
    check("sw_wdata", w, 32'h0020_A423);
    check("sw_roundtrip", dec_s(w), 32'd8);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16, 1'b0, 32'd0, 1'b1);
    wait_we(w);
    check("beq_addr", mem_addr, 32'h4);
    check("beq_wdata", w, 32'h0020_8863);
    check("beq_roundtrip", dec_b(w), 32'd16);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, 1'b1);
    wait_we(w);
    check("jal_wdata", w, 32'h0010_00EF);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'd0, 1'b1);
    wait_we(w);
    check("lui_wdata", w, 32'h1234_52B7);
    wait_idle();
    check_status("enc");

    // Range errors: nothing written, pointer held, errors counted
    do_reset();
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, 1'b1);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0, 1'b1);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'd0, 1'b1);
    send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    wait_idle();
    check("rerr_err", {31'd0, err}, 32'd1);
    check("rerr_cnt", {24'd0, err_cnt}, 32'd4);
    check("rerr_ptr", mem_addr, 32'd0);
    check_status("rerr");

    // IMEM stall: outputs hold, new bundle and base_load are ignored
    mem_ready = 1'b0;
    send(7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b0, 32'd0, 1'b1);
    wait_we(w);
    a = mem_addr;
    opcode = 7'h13; rd_addr = 5'd9; imm = 32'd5; in_valid = 1'b1;
    base_load = 1'b1; base_addr = 32'h0000_1000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_we", {31'd0, mem_we}, 32'd1);
      check("stall_addr", mem_addr, a);
      check("stall_wdata", mem_wdata, w);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; base_load = 1'b0;
    mem_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("stall_q_empty", 32'(sb_q.size()), 32'd0);
    check_status("stall");

    // base_load with in_valid in the same cycle, pointer wraps past the top
    send(7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1, 32'hFFFF_FFFC, 1'b1);
    wait_idle();
    check("wrap_ptr", mem_addr, 32'd0);

    // Reset during WRITE abandons the write
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    mem_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'd0, 1'b0);
    wait_we(w);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstw_we", {31'd0, mem_we}, 32'd0);
    check("rstw_addr", mem_addr, 32'd0);
    check("rstw_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rstw_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    m_ptr = 32'd0; m_err = 1'b0; m_err_cnt = 0;
    sb_q.delete();
    mem_ready = 1'b1;

    // Randomized bundles with random IMEM backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 120; n++) begin
      logic [31:0] iv;
      logic [6:0] op;
      bit do_base;
      logic [31:0] base;
      op = ($urandom_range(0, 15) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 4))
        0: iv = $urandom();
        1: iv = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: iv = $urandom() & 32'hFFFF_F000;
        3: iv = 32'($urandom_range(0, 40));
        default: iv = (32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000) & 32'hFFFF_FFFE;
      endcase
      do_base = ($urandom_range(0, 15) == 0);
      base = $urandom() & 32'hFFFF_FFFC;
      send(op, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()), 7'($urandom()),
           iv, do_base, base, 1'b1);
    end
    wait_idle();
    rand_rdy = 1'b0;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_q_empty", 32'(sb_q.size()), 32'd0);
    check_status("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
